// File: rtl/tx_packet_ctrl.sv
// ---------------------------------------------------------------------------
// tx_packet_ctrl
//   Sequences a single USB full-speed packet into the NRZI encoder:
//   SYNC, PID, optional payload bytes popped from the TX FIFO, CRC16 (lo, hi),
//   then an EOP phase followed by a one-cycle eop_end (J state). Only one
//   packet is ever in flight; tx_start is looked at only while idle.
//
// Ports
//   clk            system clock, the encoder shifts one bit per clk
//   n_rst          asynchronous active-low reset
//   tx_start       one-cycle request from the protocol layer
//   tx_pid         4-bit PID; byte on the wire is {~pid, pid}
//   tx_has_data    1: payload + CRC16 follow the PID, 0: PID-only packet
//   tx_byte_count  payload length, clamped to MAX_BYTES when latched
//   fifo_rdata     show-ahead FIFO head byte (valid while !fifo_empty)
//   fifo_empty     FIFO empty flag
//   fifo_ren       one-cycle pop strobe
//   enc_data       byte to the encoder, stable from enc_enable until done
//   enc_enable     one-cycle start pulse to the encoder
//   enc_eop        encoder eop (SE0), held EOP_CYCLES cycles
//   enc_eop_end    one-cycle encoder eop_end pulse
//   enc_busy       encoder busy; a low sample while waiting = byte finishing
//   tx_busy        high from tx_start accept until tx_done
//   tx_done        one-cycle pulse at packet end (normal or aborted)
//   tx_error       one-cycle pulse with tx_done when the packet was aborted
//   dbg_state      current FSM state (state_t encoding)
//
// Encoder handshake: a byte is offered by holding enc_data and pulsing
// enc_enable for exactly one cycle (ISSUE). The controller then sits in WAIT,
// holding enc_data, until it samples enc_busy low; the next ISSUE happens on
// the following cycle. enc_busy is ignored in every other phase.
// ---------------------------------------------------------------------------
module tx_packet_ctrl #(
  parameter int MAX_BYTES  = 64,  // must fit in 7 bits
  parameter int EOP_CYCLES = 2    // >= 1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic       tx_has_data,
  input  logic [6:0] tx_byte_count,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_ren,
  output logic [7:0] enc_data,
  output logic       enc_enable,
  output logic       enc_eop,
  output logic       enc_eop_end,
  input  logic       enc_busy,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SYNC    = 4'd1,
    S_PID     = 4'd2,
    S_DATA    = 4'd3,
    S_CRC_LO  = 4'd4,
    S_CRC_HI  = 4'd5,
    S_EOP     = 4'd6,
    S_EOP_END = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  localparam int EW = (EOP_CYCLES > 1) ? $clog2(EOP_CYCLES) : 1;

  state_t        state_q, state_d;
  logic          in_wait_q, in_wait_d;   // 0 = ISSUE phase, 1 = WAIT phase
  logic [3:0]    pid_q;
  logic          has_data_q;
  logic [6:0]    remaining_q;
  logic [15:0]   crc_q;
  logic [7:0]    data_q;
  logic          abort_q;
  logic [EW-1:0] eop_cnt_q;
  logic          busy_q;

  logic          byte_state;
  logic          underrun;
  logic          load_byte;
  logic          eop_last;
  logic [7:0]    issue_byte;
  logic [6:0]    count_clamped;

  // Reflected CRC16 (poly 0x8005 as 0xA001), eight data bits LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign count_clamped = (tx_byte_count > 7'(MAX_BYTES)) ? 7'(MAX_BYTES) : tx_byte_count;

  assign byte_state = (state_q == S_SYNC) || (state_q == S_PID) || (state_q == S_DATA) ||
                      (state_q == S_CRC_LO) || (state_q == S_CRC_HI);
  // An empty FIFO at a payload ISSUE aborts the packet straight into EOP.
  assign underrun   = (state_q == S_DATA) && !in_wait_q && fifo_empty;
  assign load_byte  = byte_state && !in_wait_q && !underrun;
  assign eop_last   = (eop_cnt_q == EW'(EOP_CYCLES - 1));

  always_comb begin
    issue_byte = data_q;
    case (state_q)
      S_SYNC:   issue_byte = 8'h80;
      S_PID:    issue_byte = {~pid_q, pid_q};
      S_DATA:   issue_byte = fifo_rdata;
      S_CRC_LO: issue_byte = ~crc_q[7:0];
      S_CRC_HI: issue_byte = ~crc_q[15:8];
      default:  issue_byte = data_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      in_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_wait_q <= in_wait_d;
    end
  end

  // Next state and strobes
  always_comb begin
    state_d     = state_q;
    in_wait_d   = in_wait_q;
    enc_enable  = 1'b0;
    fifo_ren    = 1'b0;
    enc_eop     = 1'b0;
    enc_eop_end = 1'b0;
    tx_done     = 1'b0;
    tx_error    = 1'b0;
    enc_data    = data_q;

    case (state_q)
      S_IDLE: begin
        if (tx_start) begin
          state_d   = S_SYNC;
          in_wait_d = 1'b0;
        end
      end

      S_SYNC, S_PID, S_DATA, S_CRC_LO, S_CRC_HI: begin
        if (!in_wait_q) begin
          if (underrun) begin
            state_d = S_EOP;
          end else begin
            enc_enable = 1'b1;
            enc_data   = issue_byte;
            fifo_ren   = (state_q == S_DATA);
            in_wait_d  = 1'b1;
          end
        end else if (!enc_busy) begin
          in_wait_d = 1'b0;
          case (state_q)
            S_SYNC:   state_d = S_PID;
            S_PID:    state_d = !has_data_q ? S_EOP :
                                (remaining_q == 7'd0) ? S_CRC_LO : S_DATA;
            // remaining_q was already decremented at this byte's ISSUE
            S_DATA:   state_d = (remaining_q == 7'd0) ? S_CRC_LO : S_DATA;
            S_CRC_LO: state_d = S_CRC_HI;
            default:  state_d = S_EOP;
          endcase
        end
      end

      S_EOP: begin
        enc_eop    = 1'b1;
        enc_enable = (eop_cnt_q == '0);
        if (eop_last) state_d = S_EOP_END;
      end

      S_EOP_END: begin
        enc_eop_end = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        tx_done  = 1'b1;
        tx_error = abort_q;
        state_d  = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        in_wait_d = 1'b0;
      end
    endcase
  end

  // Packet context, CRC and byte holding register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pid_q       <= 4'h0;
      has_data_q  <= 1'b0;
      remaining_q <= 7'd0;
      crc_q       <= 16'hFFFF;
      data_q      <= 8'h00;
      abort_q     <= 1'b0;
      eop_cnt_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tx_start) begin
            pid_q       <= tx_pid;
            has_data_q  <= tx_has_data;
            remaining_q <= count_clamped;
            crc_q       <= 16'hFFFF;
            eop_cnt_q   <= '0;
            busy_q      <= 1'b1;
          end
        end
        S_DATA: begin
          if (!in_wait_q) begin
            if (fifo_empty) begin
              abort_q <= 1'b1;
            end else begin
              crc_q       <= crc16_byte(crc_q, fifo_rdata);
              remaining_q <= remaining_q - 7'd1;
            end
          end
        end
        S_EOP: begin
          eop_cnt_q <= eop_last ? '0 : eop_cnt_q + EW'(1);
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          abort_q <= 1'b0;
        end
        default: ;
      endcase
      if (load_byte) data_q <= issue_byte;
    end
  end

  assign tx_busy   = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_packet_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_ctrl
//   Bench for tx_packet_ctrl: a behavioural encoder (busy for enc_bits cycles
//   per byte) and a show-ahead FIFO queue drive the DUT; a negedge monitor
//   collects every byte handed to the encoder plus EOP/done/error activity.
//   Expected byte streams come from a packet-level model (byte list + CRC16
//   run over the message bit stream).
// ---------------------------------------------------------------------------
module tb_tx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_has_data;
  logic [6:0] tx_byte_count;
  logic [7:0] fifo_rdata;
  logic       fifo_empty;
  logic       fifo_ren;
  logic [7:0] enc_data;
  logic       enc_enable;
  logic       enc_eop;
  logic       enc_eop_end;
  logic       enc_busy;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [3:0] dbg_state;

  always #5 clk = ~clk;

  tx_packet_ctrl #(.MAX_BYTES(64), .EOP_CYCLES(2)) dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .tx_has_data(tx_has_data), .tx_byte_count(tx_byte_count),
    .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
    .enc_data(enc_data), .enc_enable(enc_enable), .enc_eop(enc_eop),
    .enc_eop_end(enc_eop_end), .enc_busy(enc_busy), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- FIFO and encoder models ----------------
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic fifo_refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  int   enc_bits = 8;
  int   bcnt = 0;
  logic arm_pend = 1'b0;
  logic pop_pend = 1'b0;
  logic [7:0] last_byte = 8'h00;

  int ren_cnt, eop_cycles, eop_en_cnt, eop_end_cnt, done_cnt, err_cnt;
  int lone_err, ren_empty_err, stab_err;

  task automatic clear_mon();
    got_q.delete();
    ren_cnt = 0; eop_cycles = 0; eop_en_cnt = 0; eop_end_cnt = 0;
    done_cnt = 0; err_cnt = 0; lone_err = 0; ren_empty_err = 0; stab_err = 0;
  endtask

  // Monitor: sample DUT outputs mid-cycle
  always @(negedge clk) begin
    if (n_rst) begin
      if (enc_enable && !enc_eop) begin
        got_q.push_back(enc_data);
        last_byte = enc_data;
        arm_pend  = 1'b1;
      end else if (bcnt != 0 && enc_data !== last_byte) begin
        stab_err++;
      end
      if (fifo_ren) begin
        ren_cnt++;
        if (fifo_empty) ren_empty_err++;
        pop_pend = 1'b1;
      end
      if (enc_eop) begin
        eop_cycles++;
        if (enc_enable) eop_en_cnt++;
      end
      if (enc_eop_end) eop_end_cnt++;
      if (tx_done) begin
        done_cnt++;
        if (tx_error) err_cnt++;
      end else if (tx_error) begin
        lone_err++;
      end
    end
  end

  // Encoder / FIFO side effects just after the active edge
  always @(posedge clk) begin
    #1;
    if (!n_rst) begin
      bcnt = 0;
      arm_pend = 1'b0;
      pop_pend = 1'b0;
    end else begin
      if (arm_pend) bcnt = enc_bits;
      else if (bcnt > 0) bcnt--;
      if (pop_pend && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        fifo_refresh();
      end
      arm_pend = 1'b0;
      pop_pend = 1'b0;
    end
    enc_busy = (bcnt != 0);
  end

  // ---------------- packet-level reference model ----------------
  logic exp_err;
  int   exp_ren;

  task automatic build_expect(input logic [3:0] pid, input logic hd, input int cnt,
                              input logic [7:0] snap[$]);
    int n;
    logic [15:0] crc;
    logic bits[$];
    exp_q.delete();
    exp_q.push_back(8'h80);
    exp_q.push_back({~pid, pid});
    exp_err = 1'b0;
    exp_ren = 0;
    if (hd) begin
      n = (cnt > 64) ? 64 : cnt;
      if (snap.size() < n) begin
        exp_err = 1'b1;
        n = snap.size();
      end
      exp_ren = n;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(snap[i]);
        for (int b = 0; b < 8; b++) bits.push_back(snap[i][b]);
      end
      if (!exp_err) begin
        crc = 16'hFFFF;
        foreach (bits[k]) begin
          if (crc[0] ^ bits[k]) crc = (crc >> 1) ^ 16'hA001;
          else                  crc = crc >> 1;
        end
        crc = ~crc;
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic start_pkt(input logic [3:0] pid, input logic hd, input logic [6:0] cnt);
    @(posedge clk); #1;
    tx_pid = pid; tx_has_data = hd; tx_byte_count = cnt; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    // Inputs change after the accept; the latched copy must be used.
    tx_pid = ~pid; tx_has_data = ~hd; tx_byte_count = 7'd5;
  endtask

  task automatic run_packet(input string tag, input logic [3:0] pid, input logic hd,
                            input logic [6:0] cnt, input int poke);
    logic [7:0] snap[$];
    int cyc;
    int nmin;
    snap = fifo_q;
    build_expect(pid, hd, int'(cnt), snap);
    clear_mon();
    start_pkt(pid, hd, cnt);
    check({tag, "_busy_start"}, tx_busy, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      tx_start = (cyc == poke);
    end
    tx_start = 1'b0;
    if (done_cnt == 0) check({tag, "_timeout"}, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_nbytes"}, got_q.size(), exp_q.size());
    nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++)
      check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_ren"}, ren_cnt, exp_ren);
    check({tag, "_eop_cycles"}, eop_cycles, 2);
    check({tag, "_eop_enable"}, eop_en_cnt, 1);
    check({tag, "_eop_end"}, eop_end_cnt, 1);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_error"}, err_cnt, exp_err);
    check({tag, "_lone_error"}, lone_err, 0);
    check({tag, "_ren_empty"}, ren_empty_err, 0);
    check({tag, "_data_stable"}, stab_err, 0);
    check({tag, "_busy_end"}, tx_busy, 0);
    check({tag, "_idle"}, dbg_state, 0);
  endtask

  task automatic preload(input int n, input logic rnd);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i));
    fifo_refresh();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    string      name;
    logic [3:0] pid;
    logic       hd;
    logic [6:0] cnt;
    int         nfifo;
    logic [7:0] exp_pid_byte;
    int         exp_payload;
    logic       exp_error;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int nv;
    vecs[0] = '{"ack",        4'h2, 1'b0, 7'd0,   0,  8'hD2, 0,  1'b0};
    vecs[1] = '{"data0_zero", 4'h3, 1'b1, 7'd0,   0,  8'hC3, 0,  1'b0};
    vecs[2] = '{"data1_4",    4'hB, 1'b1, 7'd4,   4,  8'h4B, 4,  1'b0};
    vecs[3] = '{"underrun",   4'h3, 1'b1, 7'd3,   1,  8'hC3, 1,  1'b1};
    vecs[4] = '{"clamp",      4'h3, 1'b1, 7'd100, 64, 8'hC3, 64, 1'b0};
    vecs[5] = '{"token",      4'h1, 1'b0, 7'd5,   2,  8'hE1, 0,  1'b0};

    n_rst = 1'b0; tx_start = 1'b0; tx_pid = 4'h0; tx_has_data = 1'b0;
    tx_byte_count = 7'd0; enc_busy = 1'b0;
    fifo_refresh();
    clear_mon();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_fifo_ren", fifo_ren, 0);
    check("rst_enc_data", enc_data, 8'h00);
    check("rst_enc_enable", enc_enable, 0);
    check("rst_enc_eop", enc_eop, 0);
    check("rst_enc_eop_end", enc_eop_end, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_tx_error", tx_error, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    n_rst = 1'b1;

    // Table-driven directed packets
    foreach (vecs[v]) begin
      preload(vecs[v].nfifo, 1'b0);
      run_packet(vecs[v].name, vecs[v].pid, vecs[v].hd, vecs[v].cnt, 0);
      if (got_q.size() > 1) check({vecs[v].name, "_pid_byte"}, got_q[1], vecs[v].exp_pid_byte);
      else                  check({vecs[v].name, "_pid_present"}, got_q.size(), 2);
      check({vecs[v].name, "_payload_pops"}, ren_cnt, vecs[v].exp_payload);
      check({vecs[v].name, "_tbl_error"}, err_cnt, vecs[v].exp_error);
    end
    check("token_fifo_untouched", fifo_q.size(), 2);

    // tx_start pulsed mid-packet: ignored, exactly one packet
    preload(2, 1'b1);
    run_packet("midstart", 4'hB, 1'b1, 7'd2, 15);
    nv = got_q.size();
    repeat (40) @(posedge clk);
    #1;
    check("midstart_no_second_bytes", got_q.size(), nv);
    check("midstart_no_second_done", done_cnt, 1);
    check("midstart_busy", tx_busy, 0);

    // Reset asserted during DATA
    preload(10, 1'b1);
    clear_mon();
    start_pkt(4'h3, 1'b1, 7'd10);
    nv = 0;
    while (ren_cnt < 2 && nv < 500) begin
      @(posedge clk); #1;
      nv++;
    end
    check("midreset_reached_data", (ren_cnt >= 2), 1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midreset_state", dbg_state, 0);
    check("midreset_enc_data", enc_data, 8'h00);
    check("midreset_enable", enc_enable, 0);
    check("midreset_ren", fifo_ren, 0);
    check("midreset_eop", enc_eop, 0);
    check("midreset_busy", tx_busy, 0);
    check("midreset_done", tx_done, 0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    clear_mon();
    repeat (40) @(posedge clk);
    #1;
    check("midreset_no_done", done_cnt, 0);
    check("midreset_no_eop", eop_cycles + eop_end_cnt, 0);
    check("midreset_no_bytes", got_q.size(), 0);

    // Randomised packets against the model
    for (int r = 0; r < 20; r++) begin
      logic [3:0] pid;
      logic hd;
      int cnt, n, nf;
      pid = 4'($urandom_range(0, 15));
      hd  = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 80);
      n   = (cnt > 64) ? 64 : cnt;
      if (hd && n > 0 && $urandom_range(0, 3) == 0) nf = $urandom_range(0, n - 1);
      else if (hd)                                   nf = n + $urandom_range(0, 2);
      else                                           nf = $urandom_range(0, 3);
      enc_bits = $urandom_range(3, 10);
      preload(nf, 1'b1);
      run_packet($sformatf("rand%0d", r), pid, hd, 7'(cnt), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
